data_path: RTL and testbench
============================

// Module: data_path
// PURPOSE
//  Single-bus 32-bit CPU datapath: register file, special registers, ALU, memory-data capture.
//  Control unit/bench drives one-hot *out (bus source) and *in (load enable) strobes each cycle.
//  Sits between the control sequencer and memory.
// PARAMETERS
//  WIDTH 32 datapath word width (Z is 2*WIDTH)
// PORTS
//  clock             in  1   rising-edge clock
//  clear             in  1   async active-low reset
//  PCout,Zhighout,Zlowout,MDRout  in 1 each  bus source selects
//  R0out..R15out,HIout,LOout      in 1 each  bus source selects
//  MARin,PCin,MDRin,IRin,Yin      in 1 each  load enables
//  R0in..R15in,HIin,LOin,ZHighIn,ZLowIn  in 1 each  load enables
//  IncPC             in  1   PC <= PC+1
//  Read              in  1   MDR input mux: 1=Mdatain, 0=bus
//  Cin               in  1   carry-in to ADD
//  opcode            in  5   ALU operation
//  Mdatain           in  32  memory read data
//  BusMuxOut         out 32  current bus value
//  IR_q,PC_q,MAR_q   out 32  register taps
//  Z_q               out 64  {ZHigh,ZLow}
// BEHAVIOUR
//  - clear=0: every register (R0-R15,HI,LO,PC,IR,MAR,MDR,Y,ZHigh,ZLow) -> 0 immediately.
//  - Bus combinational; fixed priority if several sources high: MDR>PC>Zlow>Zhigh>HI>LO>R0..R15;
//    no source -> bus=0.
//  - All loads on rising clock when enable high; value = bus (MDR: Read?Mdatain:bus).
//  - PC: IncPC has priority over PCin; PC+1 wraps at 2^32.
//  - Y feeds ALU operand A; bus is operand B; ALU combinational, result captured into Z on
//    ZLowIn (bits31:0) / ZHighIn (bits63:32), independently.
//  - opcode: 00011 ADD A+B+Cin; 00100 SUB A-B; 00101 AND; 00110 OR; 00111 ROR A by B[4:0];
//    01000 ROL; 01001 SHR; 01010 SHRA; 01011 SHL; 01111 MUL signed 64b; 10000 DIV
//    (low=quotient, high=remainder, signed; B=0 -> result 0); 10001 NEG -B; 10010 NOT ~B;
//    other codes -> 0. 32-bit ops zero the high word. Arithmetic wraps mod 2^32.
//  - Reg load and bus read same cycle: read returns old value (bus before edge).
//  - Latency: source->dest transfer 1 cycle; ALU op = Yin cycle + Z cycle + Zlowout cycle.
// CONFIGURATION
//  DATAPATH_MULDIV_EN defined: MUL/DIV implemented as above.
//  Undefined: opcodes 01111/10000 produce Z=0; no multiplier/divider synthesised.
// STRUCTURE
//  Package datapath_pkg: opcode localparams (OP_ADD..OP_NOT), WIDTH constant.
//  Sub-module alu (opcode, A, B, Cin -> 64-bit result); registers and bus mux in top.
// TESTING
//  1 Reset: clear=0 mid-run -> all taps and Z_q=0 at once; clear=1 -> hold 0 until loaded.
//  2 Load: Mdatain=0x12, Read+MDRin 1 cycle, then MDRout+R4in -> R4=0x12 (R4out bus=0x12).
//  3 SUB: R3=0x18,R7=0x14; R3out+Yin; R7out+opcode 00100+ZLowIn; Zlowout+R4in -> R4=0x4.
//  4 SUB negative: Y=0x14, B=0x18 -> ZLow=0xFFFFFFFC; ZHigh unchanged.
//  5 PC: PC=0x7, IncPC+PCin with MDRout -> PC=0x8; PC=0xFFFFFFFF +1 -> 0.
//  6 MUL (macro on): Y=0xFFFFFFFE, B=3 -> Z=0xFFFFFFFF_FFFFFFFA; macro off -> Z=0.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared constants for the single-bus CPU datapath: word width and ALU opcodes.
package datapath_pkg;
    localparam int WIDTH = 32;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
endpackage

// File: rtl/data_path_alu.sv
// Combinational ALU: operand A from Y, operand B from the bus, 2*W-bit result for Z.
// MUL/DIV hardware exists only when DATAPATH_MULDIV_EN is defined.
module alu
    import datapath_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [4:0]     opcode,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           cin,
    output logic [2*W-1:0] result
);
    localparam int SW = $clog2(W);

    logic [SW-1:0]  sh;
    logic [2*W-1:0] dbl;
    logic [2*W-1:0] ror_v;
    logic [2*W-1:0] rol_v;

    // Rotates come from shifting a doubled copy of A.
    assign sh    = b[SW-1:0];
    assign dbl   = {a, a};
    assign ror_v = dbl >> sh;
    assign rol_v = dbl << sh;

`ifdef DATAPATH_MULDIV_EN
    logic signed [2*W-1:0] prod;
    logic signed [W:0]     ax;
    logic signed [W:0]     bx;

    assign prod = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    // One extra bit keeps MIN/-1 from overflowing the divider.
    assign ax   = $signed({a[W-1], a});
    assign bx   = $signed({b[W-1], b});
`endif

    always_comb begin
        result = '0;
        case (opcode)
            OP_ADD:  result[W-1:0] = a + b + W'(cin);
            OP_SUB:  result[W-1:0] = a - b;
            OP_AND:  result[W-1:0] = a & b;
            OP_OR:   result[W-1:0] = a | b;
            OP_ROR:  result[W-1:0] = ror_v[W-1:0];
            OP_ROL:  result[W-1:0] = rol_v[2*W-1:W];
            OP_SHR:  result[W-1:0] = a >> sh;
            OP_SHRA: result[W-1:0] = $signed(a) >>> sh;
            OP_SHL:  result[W-1:0] = a << sh;
`ifdef DATAPATH_MULDIV_EN
            OP_MUL:  result = prod;
            OP_DIV:  if (b != '0) result = {W'(ax % bx), W'(ax / bx)};
`endif
            OP_NEG:  result[W-1:0] = -b;
            OP_NOT:  result[W-1:0] = ~b;
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/data_path.sv
// Single-bus 32-bit datapath: register file, special registers, bus mux, ALU, MDR capture.
// Optional MUL/DIV support is enabled by defining DATAPATH_MULDIV_EN.
module data_path
    import datapath_pkg::*;
#(
    parameter int WIDTH = datapath_pkg::WIDTH
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               PCout, Zhighout, Zlowout, MDRout,
    input  logic               R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    input  logic               R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic               HIout, LOout,
    input  logic               MARin, PCin, MDRin, IRin, Yin,
    input  logic               R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
    input  logic               R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic               HIin, LOin, ZHighIn, ZLowIn,
    input  logic               IncPC,
    input  logic               Read,
    input  logic               Cin,
    input  logic [4:0]         opcode,
    input  logic [WIDTH-1:0]   Mdatain,
    output logic [WIDTH-1:0]   BusMuxOut,
    output logic [WIDTH-1:0]   IR_q,
    output logic [WIDTH-1:0]   PC_q,
    output logic [WIDTH-1:0]   MAR_q,
    output logic [2*WIDTH-1:0] Z_q
);
    logic [15:0]            rout, rin;
    logic [15:0][WIDTH-1:0] rf;
    logic [WIDTH-1:0]       bus, pc, ir, mar, mdr, y, hi, lo, zhi, zlo;
    logic [2*WIDTH-1:0]     alu_res;

    assign rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                   R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
    assign rin  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

    // Later assignments win, so the lowest-priority source is written first.
    always_comb begin
        bus = '0;
        for (int i = 15; i >= 0; i--)
            if (rout[i]) bus = rf[i];
        if (LOout)    bus = lo;
        if (HIout)    bus = hi;
        if (Zhighout) bus = zhi;
        if (Zlowout)  bus = zlo;
        if (PCout)    bus = pc;
        if (MDRout)   bus = mdr;
    end

    genvar g;
    generate
        for (g = 0; g < 16; g++) begin : g_rf
            always_ff @(posedge clock or negedge clear) begin
                if (!clear)      rf[g] <= '0;
                else if (rin[g]) rf[g] <= bus;
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            pc  <= '0;
            ir  <= '0;
            mar <= '0;
            mdr <= '0;
            y   <= '0;
            hi  <= '0;
            lo  <= '0;
            zhi <= '0;
            zlo <= '0;
        end else begin
            if (IncPC)        pc  <= pc + 1'b1;
            else if (PCin)    pc  <= bus;
            if (IRin)         ir  <= bus;
            if (MARin)        mar <= bus;
            if (MDRin)        mdr <= Read ? Mdatain : bus;
            if (Yin)          y   <= bus;
            if (HIin)         hi  <= bus;
            if (LOin)         lo  <= bus;
            if (ZHighIn)      zhi <= alu_res[2*WIDTH-1:WIDTH];
            if (ZLowIn)       zlo <= alu_res[WIDTH-1:0];
        end
    end

    alu #(.W(WIDTH)) u_alu (
        .opcode (opcode),
        .a      (y),
        .b      (bus),
        .cin    (Cin),
        .result (alu_res)
    );

    assign BusMuxOut = bus;
    assign IR_q      = ir;
    assign PC_q      = pc;
    assign MAR_q     = mar;
    assign Z_q       = {zhi, zlo};
endmodule

// File: tb/tb_data_path.sv
// Randomized/directed bench for data_path with a behavioural register-transfer model.
module tb_data_path;
    import datapath_pkg::*;

    // Model slots: 0 MDR,1 PC,2 ZLO,3 ZHI,4 HI,5 LO,6..21 R0..R15,22 IR,23 MAR,24 Y.
    // Source bits use slots 0..21 in bus priority order; load bits use all 25 slots.
    localparam int I_MDR = 0, I_PC = 1, I_ZLO = 2, I_ZHI = 3, I_HI = 4, I_LO = 5;
    localparam int I_R0 = 6, I_IR = 22, I_MAR = 23, I_Y = 24;

    logic        clock = 1'b0;
    logic        clear;
    logic [21:0] src;
    logic [24:0] dst;
    logic        Read, IncPC, Cin;
    logic [4:0]  opcode;
    logic [31:0] Mdatain;
    logic [31:0] BusMuxOut, IR_q, PC_q, MAR_q;
    logic [63:0] Z_q;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] m [0:24];

    always #5 clock = ~clock;

    data_path dut (
        .clock(clock), .clear(clear),
        .PCout(src[I_PC]), .Zhighout(src[I_ZHI]), .Zlowout(src[I_ZLO]), .MDRout(src[I_MDR]),
        .R0out(src[6]), .R1out(src[7]), .R2out(src[8]), .R3out(src[9]),
        .R4out(src[10]), .R5out(src[11]), .R6out(src[12]), .R7out(src[13]),
        .R8out(src[14]), .R9out(src[15]), .R10out(src[16]), .R11out(src[17]),
        .R12out(src[18]), .R13out(src[19]), .R14out(src[20]), .R15out(src[21]),
        .HIout(src[I_HI]), .LOout(src[I_LO]),
        .MARin(dst[I_MAR]), .PCin(dst[I_PC]), .MDRin(dst[I_MDR]), .IRin(dst[I_IR]), .Yin(dst[I_Y]),
        .R0in(dst[6]), .R1in(dst[7]), .R2in(dst[8]), .R3in(dst[9]),
        .R4in(dst[10]), .R5in(dst[11]), .R6in(dst[12]), .R7in(dst[13]),
        .R8in(dst[14]), .R9in(dst[15]), .R10in(dst[16]), .R11in(dst[17]),
        .R12in(dst[18]), .R13in(dst[19]), .R14in(dst[20]), .R15in(dst[21]),
        .HIin(dst[I_HI]), .LOin(dst[I_LO]), .ZHighIn(dst[I_ZHI]), .ZLowIn(dst[I_ZLO]),
        .IncPC(IncPC), .Read(Read), .Cin(Cin), .opcode(opcode), .Mdatain(Mdatain),
        .BusMuxOut(BusMuxOut), .IR_q(IR_q), .PC_q(PC_q), .MAR_q(MAR_q), .Z_q(Z_q)
    );

    function automatic logic [21:0] S(input int i);
        return 22'(1) << i;
    endfunction

    function automatic logic [24:0] D(input int i);
        return 25'(1) << i;
    endfunction

    // Reference ALU written from the operation definitions with plain arithmetic.
    function automatic logic [63:0] m_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic ci);
        logic [31:0] t;
        longint      sa, sb, q, d;
        int          n;
        t  = 32'h0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        n  = int'(b[4:0]);
        case (op)
            5'd3:  t = a + b + 32'(ci);
            5'd4:  t = a - b;
            5'd5:  t = a & b;
            5'd6:  t = a | b;
            5'd7:  begin t = a; for (int k = 0; k < n; k++) t = {t[0], t[31:1]}; end
            5'd8:  begin t = a; for (int k = 0; k < n; k++) t = {t[30:0], t[31]}; end
            5'd9:  t = a / (32'd1 << n);
            5'd10: begin
                d = longint'(1) << n;
                q = sa / d;
                if (sa < 0 && (sa % d) != 0) q = q - 1;
                t = q[31:0];
            end
            5'd11: t = a * (32'd1 << n);
`ifdef DATAPATH_MULDIV_EN
            5'd15: return sa * sb;
            5'd16: begin
                if (b == 32'h0) return 64'h0;
                q = sa / sb;
                d = sa % sb;
                return {d[31:0], q[31:0]};
            end
`endif
            5'd17: t = 32'h0 - b;
            5'd18: t = ~b;
            default: t = 32'h0;
        endcase
        return {32'h0, t};
    endfunction

    function automatic logic [31:0] m_bus(input logic [21:0] s);
        for (int i = 0; i < 22; i++)
            if (s[i]) return m[i];
        return 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_taps(input string tag);
        chk({tag, "/IR"},  {32'h0, IR_q},  {32'h0, m[I_IR]});
        chk({tag, "/PC"},  {32'h0, PC_q},  {32'h0, m[I_PC]});
        chk({tag, "/MAR"}, {32'h0, MAR_q}, {32'h0, m[I_MAR]});
        chk({tag, "/Z"},   Z_q,            {m[I_ZHI], m[I_ZLO]});
    endtask

    // One control cycle: drive after negedge, check bus, clock, update model, check taps.
    task automatic cyc(input string tag, input logic [21:0] s, input logic [24:0] d,
                       input logic rd, input logic inc, input logic ci,
                       input logic [4:0] op, input logic [31:0] md);
        logic [31:0] b;
        logic [63:0] r;
        logic [31:0] nm [0:24];
        @(negedge clock);
        src = s; dst = d; Read = rd; IncPC = inc; Cin = ci; opcode = op; Mdatain = md;
        #1;
        b = m_bus(s);
        r = m_alu(op, m[I_Y], b, ci);
        chk({tag, "/bus"}, {32'h0, BusMuxOut}, {32'h0, b});
        nm = m;
        for (int i = 0; i < 25; i++) begin
            if (d[i]) begin
                case (i)
                    I_MDR:   nm[i] = rd ? md : b;
                    I_ZLO:   nm[i] = r[31:0];
                    I_ZHI:   nm[i] = r[63:32];
                    default: nm[i] = b;
                endcase
            end
        end
        if (inc) nm[I_PC] = m[I_PC] + 32'd1;
        @(posedge clock);
        m = nm;
        #1;
        chk_taps(tag);
    endtask

    task automatic idle();
        src = '0; dst = '0; Read = 0; IncPC = 0; Cin = 0; opcode = 5'd0; Mdatain = 32'h0;
    endtask

    // Put a value into a slot through MDR.
    task automatic load(input string tag, input int slot, input logic [31:0] v);
        cyc(tag, '0, D(I_MDR), 1'b1, 1'b0, 1'b0, 5'd0, v);
        if (slot != I_MDR) cyc(tag, S(I_MDR), D(slot), 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic alu_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] op, input logic ci, input logic [24:0] zmask);
        load(tag, I_MDR, a);
        cyc(tag, S(I_MDR), D(I_Y), 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        load(tag, I_MDR, b);
        cyc(tag, S(I_MDR), zmask, 1'b0, 1'b0, ci, op, 32'h0);
    endtask

    logic [4:0]  ops [0:15] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                                5'd11, 5'd15, 5'd16, 5'd17, 5'd18, 5'd0, 5'd12, 5'd31};

    initial begin
        logic [31:0] a, b;
        logic [4:0]  op;
        int          dsl;
        idle();
        for (int i = 0; i < 25; i++) m[i] = 32'h0;
        clear = 1'b0;
        #12;
        chk_taps("reset");
        chk("reset/bus", {32'h0, BusMuxOut}, 64'h0);
        @(negedge clock);
        clear = 1'b1;

        // Memory load into R4 and readback.
        load("load", I_MDR, 32'h12);
        cyc("load", S(I_MDR), D(I_R0 + 4), 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        cyc("load_rd", S(I_R0 + 4), '0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("load/R4", {32'h0, BusMuxOut}, 64'h12);

        // SUB R3 - R7 into R4.
        load("sub", I_R0 + 3, 32'h18);
        load("sub", I_R0 + 7, 32'h14);
        cyc("sub", S(I_R0 + 3), D(I_Y), 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        cyc("sub", S(I_R0 + 7), D(I_ZLO), 1'b0, 1'b0, 1'b0, OP_SUB, 32'h0);
        cyc("sub", S(I_ZLO), D(I_R0 + 4), 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        cyc("sub_rd", S(I_R0 + 4), '0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("sub/R4", {32'h0, BusMuxOut}, 64'h4);

        // Negative SUB result, ZHigh untouched.
        alu_op("subneg", 32'h14, 32'h18, OP_SUB, 1'b0, D(I_ZLO));
        chk("subneg/Z", Z_q, 64'h0000_0000_FFFF_FFFC);

        // ADD with carry-in wraps.
        alu_op("addc", 32'hFFFF_FFFF, 32'h0, OP_ADD, 1'b1, D(I_ZLO) | D(I_ZHI));
        chk("addc/Z", Z_q, 64'h0);

        // PC increment priority and wrap.
        load("pc", I_PC, 32'h7);
        load("pc", I_MDR, 32'h55);
        cyc("pc_inc", S(I_MDR), D(I_PC), 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        chk("pc/inc", {32'h0, PC_q}, 64'h8);
        load("pc", I_PC, 32'hFFFF_FFFF);
        cyc("pc_wrap", '0, '0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        chk("pc/wrap", {32'h0, PC_q}, 64'h0);

        // MUL of -2 by 3.
        alu_op("mul", 32'hFFFF_FFFE, 32'h3, OP_MUL, 1'b0, D(I_ZLO) | D(I_ZHI));
`ifdef DATAPATH_MULDIV_EN
        chk("mul/Z", Z_q, 64'hFFFF_FFFF_FFFF_FFFA);
`else
        chk("mul/Z", Z_q, 64'h0);
`endif

        // Bus priority: fill every source with distinct values, then peel off winners.
        for (int i = 0; i < 22; i++) load("prio_ld", i, 32'hA000_0000 + 32'(i));
        for (int i = 0; i < 22; i++)
            cyc("prio", ~22'h0 << i, '0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        cyc("nosrc", '0, '0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

        // Same-cycle read/write returns the old value; MDR reloads while being read.
        cyc("rw", S(I_MDR), D(I_MDR) | D(I_R0 + 5) | D(I_IR) | D(I_MAR), 1'b1, 1'b0, 1'b0,
            5'd0, 32'hCAFE_F00D);
        cyc("rw_rd", S(I_R0 + 5), '0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

        // Randomized ALU operations routed to random destinations.
        for (int it = 0; it < 70; it++) begin
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 40);
            op = ops[$urandom_range(0, 15)];
            if (op == OP_DIV && $urandom_range(0, 5) == 0) b = 32'h0;
            if (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'h7;
            alu_op("rnd", a, b, op, 1'($urandom_range(0, 1)),
                   25'($urandom_range(1, 3)) << I_ZLO);
            dsl = $urandom_range(I_HI, I_MAR);
            cyc("rnd_mv", S($urandom_range(0, 1) ? I_ZLO : I_ZHI), D(dsl), 1'b0,
                1'($urandom_range(0, 7) == 0), 1'b0, 5'd0, 32'h0);
            cyc("rnd_rd", S(dsl < 22 ? dsl : I_ZHI), '0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        end

        // Mid-run asynchronous clear, then hold until reloaded.
        @(posedge clock);
        #2;
        clear = 1'b0;
        #1;
        for (int i = 0; i < 25; i++) m[i] = 32'h0;
        chk_taps("clr_mid");
        @(negedge clock);
        clear = 1'b1;
        for (int i = 0; i < 22; i++)
            cyc("clr_hold", S(i), '0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        cyc("clr_y", S(I_R0), D(I_ZLO), 1'b0, 1'b0, 1'b0, OP_NOT, 32'h0);
        chk("clr/notY", Z_q, 64'h0000_0000_FFFF_FFFF);

        idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
